// File: rtl/mmu_pkg.sv
// rtl/mmu_pkg.sv - shared types and defaults for the matrix-multiply controller
//
// Holds the controller FSM state encoding and the constants that set the
// default array size and array latency.
package mmu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWAP  = 2'd1,
        ST_RUN   = 2'd2,
        ST_WRITE = 2'd3
    } mmu_ctrl_state_t;

    localparam int MMU_DEFAULT_SIZE = 2;

    // The array pipeline is one PE per column deep, so the default
    // latency scales with the array size.
    localparam int MMU_ARR_LAT_PER_SIZE = 1;

endpackage

// File: rtl/mmu_mult_ctrl.sv
// rtl/mmu_mult_ctrl.sv - tile sequencer between data FIFO, systolic array and result FIFO
//
// Pops one SIZE x SIZE activation tile, optionally swaps shadow weights into
// the array, feeds the tile row-skewed into the array, captures the column
// outputs into a result tile and pushes that into the result FIFO.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   mult_run/mult_swap request a tile multiply / swap weights first
//   mult_rdy          controller idle and a data tile is available
//   data_tile         data FIFO head, [k][r] = row k, element r
//   data_pop_rdy      data FIFO non-empty
//   data_pop          pop data FIFO head
//   arr_run           array advance enable
//   arr_swap_weights  shadow-to-active weight swap pulse
//   arr_data_in       skewed activations, one per array row
//   arr_acc_out       array column outputs
//   res_tile          captured result tile, [k][c]
//   res_push_rdy      result FIFO not full
//   res_push          push res_tile into result FIFO
module mmu_mult_ctrl
    import mmu_pkg::*;
#(
    parameter int SIZE    = MMU_DEFAULT_SIZE,
    parameter int ARR_LAT = MMU_ARR_LAT_PER_SIZE * SIZE
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 mult_run,
    input  logic                                 mult_swap,
    output logic                                 mult_rdy,
    input  logic [SIZE-1:0][SIZE-1:0][7:0]       data_tile,
    input  logic                                 data_pop_rdy,
    output logic                                 data_pop,
    output logic                                 arr_run,
    output logic                                 arr_swap_weights,
    output logic [SIZE-1:0][7:0]                 arr_data_in,
    input  logic [SIZE-1:0][31:0]                arr_acc_out,
    output logic [SIZE-1:0][SIZE-1:0][31:0]      res_tile,
    input  logic                                 res_push_rdy,
    output logic                                 res_push
);

    localparam int             TW     = $clog2(3 * SIZE);
    localparam logic [TW-1:0]  T_LAST = TW'(3 * SIZE - 2);

    mmu_ctrl_state_t                   state_q, state_d;
    logic [TW-1:0]                     t_q, t_d;
    logic [SIZE-1:0][SIZE-1:0][7:0]    tile_q, tile_d;
    logic [SIZE-1:0][SIZE-1:0][31:0]   res_q, res_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            tile_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            tile_q  <= tile_d;
            res_q   <= res_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        tile_d  = tile_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE: begin
                if (mult_run && data_pop_rdy) begin
                    tile_d  = data_tile;
                    state_d = mult_swap ? ST_SWAP : ST_RUN;
                end
            end
            ST_SWAP: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // Row k reaches column c's output ARR_LAT steps after its
                // skewed entry, offset by one step per column.
                for (int k = 0; k < SIZE; k++) begin
                    for (int c = 0; c < SIZE; c++) begin
                        if (int'(t_q) == k + c + ARR_LAT) begin
                            res_d[k][c] = arr_acc_out[c];
                        end
                    end
                end
                if (t_q == T_LAST) begin
                    state_d = ST_WRITE;
                    t_d     = '0;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            ST_WRITE: begin
                if (res_push_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        mult_rdy         = (state_q == ST_IDLE) && data_pop_rdy;
        data_pop         = mult_rdy && mult_run;
        arr_run          = (state_q == ST_RUN);
        arr_swap_weights = (state_q == ST_SWAP);
        res_push         = (state_q == ST_WRITE) && res_push_rdy;
        res_tile         = res_q;
        arr_data_in      = '0;
        // Row r lags by r steps, so element r of tile row k enters at t = k + r.
        if (state_q == ST_RUN) begin
            for (int k = 0; k < SIZE; k++) begin
                for (int r = 0; r < SIZE; r++) begin
                    if (int'(t_q) == k + r) begin
                        arr_data_in[r] = tile_q[k][r];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mmu_mult_ctrl.sv
// tb/tb_mmu_mult_ctrl.sv - self-checking bench for mmu_mult_ctrl with a behavioural array model
module tb_mmu_mult_ctrl;

    localparam int SIZE    = 2;
    localparam int ARR_LAT = SIZE;

    typedef logic [1:0][1:0][7:0]  tile_t;
    typedef logic [1:0][1:0][31:0] mat_t;

    typedef struct {
        tile_t tile;
        logic  swap;
        mat_t  w;
        mat_t  exp;
        int    lat;
        int    hold;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mult_run;
    logic        mult_swap;
    logic        mult_rdy;
    tile_t       data_tile;
    logic        data_pop_rdy;
    logic        data_pop;
    logic        arr_run;
    logic        arr_swap_weights;
    logic [1:0][7:0]  arr_data_in;
    logic [1:0][31:0] arr_acc_out;
    mat_t        res_tile;
    logic        res_push_rdy;
    logic        res_push;

    int n_checks = 0;
    int n_errors = 0;

    mat_t exp_q[$];

    // Array model state
    mat_t       w_active;
    mat_t       w_shadow;
    logic       w_force;
    logic [7:0] hist [0:15][0:1];
    int         step;

    mmu_mult_ctrl #(.SIZE(SIZE), .ARR_LAT(ARR_LAT)) dut (
        .clk              (clk),
        .rst              (rst),
        .mult_run         (mult_run),
        .mult_swap        (mult_swap),
        .mult_rdy         (mult_rdy),
        .data_tile        (data_tile),
        .data_pop_rdy     (data_pop_rdy),
        .data_pop         (data_pop),
        .arr_run          (arr_run),
        .arr_swap_weights (arr_swap_weights),
        .arr_data_in      (arr_data_in),
        .arr_acc_out      (arr_acc_out),
        .res_tile         (res_tile),
        .res_push_rdy     (res_push_rdy),
        .res_push         (res_push)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (w_force) w_active <= w_shadow;
        else if (arr_swap_weights) w_active <= w_shadow;
        if (arr_run) begin
            if (step < 16) begin
                hist[step][0] <= arr_data_in[0];
                hist[step][1] <= arr_data_in[1];
            end
            step <= step + 1;
        end else begin
            step <= 0;
        end
    end

    // Weight-stationary array: column c at step s emits the dot product of
    // the tile row that entered ARR_LAT + c steps earlier with weight column c.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            logic [31:0] acc;
            acc = '0;
            for (int r = 0; r < 2; r++) begin
                int idx;
                idx = step - ARR_LAT - c + r;
                if (idx >= 0 && idx < 16)
                    acc = acc + w_active[r][c] * {24'd0, hist[idx][r]};
            end
            arr_acc_out[c] = acc;
        end
    end

    function automatic tile_t mk_tile(int a, int b, int c, int d);
        tile_t t;
        t[0][0] = 8'(a); t[0][1] = 8'(b); t[1][0] = 8'(c); t[1][1] = 8'(d);
        return t;
    endfunction

    function automatic mat_t mk_mat(int a, int b, int c, int d);
        mat_t m;
        m[0][0] = 32'(a); m[0][1] = 32'(b); m[1][0] = 32'(c); m[1][1] = 32'(d);
        return m;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_tile(input string name, input mat_t exp);
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < 2; c++)
                check($sformatf("%s[%0d][%0d]", name, k, c), 64'(res_tile[k][c]), 64'(exp[k][c]));
    endtask

    task automatic sb_pop(input string name);
        mat_t e;
        if (exp_q.size() == 0) begin
            check({name, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check_tile(name, e);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int  lat;
        int  runs;
        int  swaps;
        bit  done;
        w_shadow = v.w;
        if (!v.swap) begin
            @(negedge clk); w_force = 1'b1;
            @(negedge clk); w_force = 1'b0;
        end
        res_push_rdy = (v.hold == 0);
        @(negedge clk);
        data_tile    = v.tile;
        mult_swap    = v.swap;
        data_pop_rdy = 1'b1;
        mult_run     = 1'b1;
        #1;
        check($sformatf("v%0d_mult_rdy", id), 64'(mult_rdy), 64'd1);
        check($sformatf("v%0d_data_pop", id), 64'(data_pop), 64'd1);
        exp_q.push_back(v.exp);
        @(posedge clk); #1;
        mult_run = 1'b0; data_pop_rdy = 1'b0; mult_swap = 1'b0;
        lat = 0; runs = 0; swaps = 0; done = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            runs  += int'(arr_run);
            swaps += int'(arr_swap_weights);
            if (res_push) begin
                check($sformatf("v%0d_latency", id), 64'(lat), 64'(v.lat));
                sb_pop($sformatf("v%0d_res", id));
                done = 1;
            end else if (lat == v.lat && v.hold > 0) begin
                data_pop_rdy = 1'b1;
                for (int i = 0; i < v.hold; i++) begin
                    #1;
                    check($sformatf("v%0d_hold_push", id), 64'(res_push), 64'd0);
                    check($sformatf("v%0d_hold_rdy", id), 64'(mult_rdy), 64'd0);
                    check_tile($sformatf("v%0d_hold_tile", id), v.exp);
                    @(negedge clk);
                end
                res_push_rdy = 1'b1;
                #1;
                check($sformatf("v%0d_push_on_rdy", id), 64'(res_push), 64'd1);
                sb_pop($sformatf("v%0d_res", id));
                data_pop_rdy = 1'b0;
                done = 1;
            end
        end
        if (!done) check($sformatf("v%0d_timeout", id), 64'd0, 64'd1);
        check($sformatf("v%0d_run_cycles", id), 64'(runs), 64'(3 * SIZE - 1));
        check($sformatf("v%0d_swap_pulses", id), 64'(swaps), 64'(v.swap));
        @(posedge clk); #1;
        res_push_rdy = 1'b1;
    endtask

    vec_t vecs[4];
    int   skew_exp [0:4][0:1];

    initial begin
        rst = 1'b1; mult_run = 1'b0; mult_swap = 1'b0; data_tile = '0;
        data_pop_rdy = 1'b0; res_push_rdy = 1'b1;
        w_force = 1'b0; w_shadow = '0;

        vecs[0] = '{mk_tile(1, 2, 3, 4),     1'b0, mk_mat(1, 0, 0, 1), mk_mat(1, 2, 3, 4),      6, 0};
        vecs[1] = '{mk_tile(1, 2, 3, 4),     1'b1, mk_mat(2, 0, 0, 2), mk_mat(2, 4, 6, 8),      7, 0};
        vecs[2] = '{mk_tile(5, 6, 7, 8),     1'b0, mk_mat(1, 2, 3, 4), mk_mat(23, 34, 31, 46),  6, 10};
        vecs[3] = '{mk_tile(255, 1, 0, 200), 1'b1, mk_mat(3, 0, 1, 5), mk_mat(766, 5, 200, 1000), 7, 0};
        skew_exp = '{'{1, 0}, '{3, 2}, '{0, 4}, '{0, 0}, '{0, 0}};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mult_rdy", 64'(mult_rdy), 64'd0);
        check("rst_data_pop", 64'(data_pop), 64'd0);
        check("rst_arr_run", 64'(arr_run), 64'd0);
        check("rst_swap", 64'(arr_swap_weights), 64'd0);
        check("rst_res_push", 64'(res_push), 64'd0);
        check("rst_data_in", 64'(arr_data_in), 64'd0);
        check_tile("rst_res", mk_mat(0, 0, 0, 0));
        rst = 1'b0;

        // Request without data available is ignored
        @(negedge clk);
        mult_run = 1'b1; data_pop_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("nodata_mult_rdy", 64'(mult_rdy), 64'd0);
            check("nodata_pop", 64'(data_pop), 64'd0);
            check("nodata_arr_run", 64'(arr_run), 64'd0);
            @(negedge clk);
        end
        mult_run = 1'b0; data_pop_rdy = 1'b1; #1;
        check("nodata_still_idle", 64'(mult_rdy), 64'd1);
        data_pop_rdy = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i], i);
            if (i == 0) begin
                for (int s = 0; s < 5; s++)
                    for (int r = 0; r < 2; r++)
                        check($sformatf("skew_t%0d_r%0d", s, r), 64'(hist[s][r]), 64'(skew_exp[s][r]));
            end
        end

        // Reset during RUN at t=2 aborts the tile
        @(negedge clk);
        data_tile = mk_tile(9, 9, 9, 9); data_pop_rdy = 1'b1; mult_run = 1'b1;
        @(posedge clk); #1;
        mult_run = 1'b0; data_pop_rdy = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_in_run", 64'(arr_run), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_arr_run", 64'(arr_run), 64'd0);
        check("abort_data_pop", 64'(data_pop), 64'd0);
        check("abort_swap", 64'(arr_swap_weights), 64'd0);
        check("abort_res_push", 64'(res_push), 64'd0);
        check("abort_data_in", 64'(arr_data_in), 64'd0);
        check_tile("abort_res", mk_mat(0, 0, 0, 0));
        begin
            int pushes;
            pushes = 0;
            repeat (12) begin
                @(negedge clk);
                pushes += int'(res_push);
            end
            check("abort_no_push", 64'(pushes), 64'd0);
        end
        run_vec(vecs[0], 4);
        run_vec(vecs[1], 5);

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
